// File: rtl/fuzzy_rule_sequencer.sv
// Rule-walk sequencer for the two-input interval type-2 fuzzy controller:
// scans the rule base, accumulates centroid sums and drives the shared divider.
module fuzzy_rule_sequencer #(
  parameter int N_FOU  = 3,
  parameter int W_DADO = 8,
  parameter int W_ACC  = 24,
  parameter int W_IDX  = 4
) (
  input  logic                clk_0,
  input  logic                Srst_n,
  input  logic                EN_REGRAS,
  input  logic                inicio,
  input  logic [2*N_FOU-1:0]  FOU_ATIVO,
  output logic                ocupado,
  output logic                reset_mem,
  output logic [W_IDX-1:0]    regra_idx,
  output logic                regra_req,
  input  logic                fire_valid,
  input  logic [W_DADO-1:0]   w_up,
  input  logic [W_DADO-1:0]   w_low,
  input  logic [W_DADO-1:0]   centroide,
  output logic                div_start,
  output logic [W_ACC-1:0]    div_num,
  output logic [W_ACC-1:0]    div_den,
  input  logic                div_done,
  input  logic [W_DADO-1:0]   div_quoc,
  output logic [W_DADO-1:0]   saida_defuzzy,
  output logic                saida_valida,
  output logic                sem_regra
);

  // state     | meaning
  // IDLE      | waiting for inicio with EN_REGRAS
  // CLR_MEM   | one-cycle membership-memory clear
  // SCAN      | test rule k against the latched mask
  // WAIT_FIRE | regra_req held until fire_valid, then accumulate
  // DIV_START | one-cycle divider start
  // DIV_WAIT  | waiting for div_done
  // FIM       | one-cycle result strobe
  typedef enum logic [2:0] {
    IDLE, CLR_MEM, SCAN, WAIT_FIRE, DIV_START, DIV_WAIT, FIM
  } state_t;

  localparam logic [W_IDX-1:0] LAST_K = W_IDX'(N_FOU * N_FOU - 1);
  localparam int               N_SLOT = 2 ** W_IDX;

  state_t               state_q, state_d;
  logic [W_IDX-1:0]     k_q, k_d;
  logic [W_ACC-1:0]     num_q, num_d, den_q, den_d;
  logic [2*N_FOU-1:0]   mask_q, mask_d;
  logic [W_DADO-1:0]    saida_q, saida_d;
  logic                 sem_q, sem_d;

  logic [N_SLOT-1:0]    rule_act;
  logic [W_DADO:0]      soma;
  logic [2*W_DADO:0]    prod;
  logic                 fim_regras;
  logic [W_ACC-1:0]     den_final;

  // Rule k = i*N_FOU + j is live when both of its input FOUs are active.
  always_comb begin
    rule_act = '0;
    for (int i = 0; i < N_FOU; i++)
      for (int j = 0; j < N_FOU; j++)
        rule_act[i*N_FOU + j] = mask_q[i] & mask_q[N_FOU + j];
  end

  assign soma = {1'b0, w_up} + {1'b0, w_low};
  assign prod = (2*W_DADO+1)'(soma) * (2*W_DADO+1)'(centroide);

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    num_d      = num_q;
    den_d      = den_q;
    mask_d     = mask_q;
    saida_d    = saida_q;
    sem_d      = sem_q;
    fim_regras = 1'b0;
    den_final  = den_q;

    if (state_q != IDLE && !EN_REGRAS) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (inicio && EN_REGRAS) begin
          state_d = CLR_MEM;
          k_d     = '0;
          num_d   = '0;
          den_d   = '0;
          mask_d  = FOU_ATIVO;
        end
        CLR_MEM: state_d = SCAN;
        SCAN: begin
          if (rule_act[k_q])       state_d = WAIT_FIRE;
          else if (k_q == LAST_K)  fim_regras = 1'b1;
          else                     k_d = k_q + 1'b1;
        end
        WAIT_FIRE: if (fire_valid) begin
          num_d     = num_q + W_ACC'(prod);
          den_d     = den_q + W_ACC'(soma);
          den_final = den_d;
          if (k_q == LAST_K) begin
            fim_regras = 1'b1;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = SCAN;
          end
        end
        DIV_START: state_d = DIV_WAIT;
        DIV_WAIT: if (div_done) begin
          saida_d = div_quoc;
          sem_d   = 1'b0;
          state_d = FIM;
        end
        FIM:     state_d = IDLE;
        default: state_d = IDLE;
      endcase

      // Zero denominator skips the divider and reports an empty rule set.
      if (fim_regras) begin
        if (den_final != '0) begin
          state_d = DIV_START;
        end else begin
          state_d = FIM;
          sem_d   = 1'b1;
          saida_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_0 or negedge Srst_n) begin
    if (!Srst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      num_q   <= '0;
      den_q   <= '0;
      mask_q  <= '0;
      saida_q <= '0;
      sem_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      num_q   <= num_d;
      den_q   <= den_d;
      mask_q  <= mask_d;
      saida_q <= saida_d;
      sem_q   <= sem_d;
    end
  end

  assign ocupado       = (state_q != IDLE);
  assign reset_mem     = (state_q == CLR_MEM);
  assign regra_req     = (state_q == WAIT_FIRE);
  assign regra_idx     = k_q;
  assign div_start     = (state_q == DIV_START);
  assign div_num       = num_q;
  assign div_den       = den_q;
  assign saida_valida  = (state_q == FIM);
  assign saida_defuzzy = saida_q;
  assign sem_regra     = sem_q;

endmodule

// File: tb/tb_fuzzy_rule_sequencer.sv
// Table-driven bench for fuzzy_rule_sequencer: each record is one full run
// with its own fire/divider responder settings and hand-computed results.
module tb_fuzzy_rule_sequencer;

  logic        clk_0 = 1'b0;
  logic        Srst_n;
  logic        EN_REGRAS;
  logic        inicio;
  logic [5:0]  FOU_ATIVO;
  logic        ocupado, reset_mem, regra_req, div_start, saida_valida, sem_regra;
  logic [3:0]  regra_idx;
  logic        fire_valid, div_done;
  logic [7:0]  w_up, w_low, centroide, div_quoc, saida_defuzzy;
  logic [23:0] div_num, div_den;

  int total = 0;
  int bad   = 0;

  fuzzy_rule_sequencer dut (
    .clk_0(clk_0), .Srst_n(Srst_n), .EN_REGRAS(EN_REGRAS), .inicio(inicio),
    .FOU_ATIVO(FOU_ATIVO), .ocupado(ocupado), .reset_mem(reset_mem),
    .regra_idx(regra_idx), .regra_req(regra_req), .fire_valid(fire_valid),
    .w_up(w_up), .w_low(w_low), .centroide(centroide), .div_start(div_start),
    .div_num(div_num), .div_den(div_den), .div_done(div_done),
    .div_quoc(div_quoc), .saida_defuzzy(saida_defuzzy),
    .saida_valida(saida_valida), .sem_regra(sem_regra)
  );

  always #5 clk_0 = ~clk_0;

  typedef struct {
    logic [5:0] mask;
    int wu, wl, cmul, cadd, quoc, div_dly;
    bit stress;
    int nreq, ndiv, num, den, out;
    bit sem;
    int lat, abort_k;
    bit rst_div;
  } scen_t;

  scen_t tbl[12];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int next_active(input logic [5:0] m, input int from);
    for (int k = from; k < 9; k++)
      if (m[k/3] && m[3 + k%3]) return k;
    return 9;
  endfunction

  task automatic run(input scen_t s, input string nm);
    int cyc = 0, nreq = 0, ndiv = 0, nrst = 0, nval = 0, div_cnt = -1, req_age = 0, exp_k;
    bit prev_req = 0, done = 0;
    exp_k      = next_active(s.mask, 0);
    fire_valid = s.stress;
    div_done   = 0;
    EN_REGRAS  = 1;
    FOU_ATIVO  = s.mask;
    inicio     = 1;
    @(negedge clk_0);
    inicio    = 0;
    FOU_ATIVO = ~s.mask;
    while (!done && cyc < 300) begin
      cyc++;
      if (reset_mem) nrst++;
      if (regra_req && !prev_req) begin
        check({nm, "_idx"}, int'(regra_idx), exp_k);
        nreq++;
        exp_k = next_active(s.mask, exp_k + 1);
        if (s.abort_k >= 0 && int'(regra_idx) == s.abort_k) begin
          EN_REGRAS  = 0;
          fire_valid = 0;
          @(negedge clk_0);
          check({nm, "_ocupado"}, int'(ocupado), 0);
          check({nm, "_req"}, int'(regra_req), 0);
          check({nm, "_kept_out"}, int'(saida_defuzzy), s.out);
          check({nm, "_kept_sem"}, int'(sem_regra), int'(s.sem));
          EN_REGRAS = 1;
          div_done  = 1;
          div_quoc  = 8'd33;
          for (int i = 0; i < 4; i++) begin
            @(negedge clk_0);
            div_done = 0;
            if (saida_valida || ocupado) nval++;
          end
          check({nm, "_late_done_ignored"}, nval, 0);
          check({nm, "_out_after"}, int'(saida_defuzzy), s.out);
          return;
        end
      end
      prev_req   = regra_req;
      req_age    = regra_req ? req_age + 1 : 0;
      fire_valid = s.stress || (regra_req && req_age >= 2);
      w_up       = 8'(s.wu);
      w_low      = 8'(s.wl);
      centroide  = 8'(s.cmul * int'(regra_idx) + s.cadd);
      div_done   = 0;
      if (div_start) begin
        ndiv++;
        check({nm, "_div_num"}, int'(div_num), s.num);
        check({nm, "_div_den"}, int'(div_den), s.den);
        div_cnt = s.div_dly;
      end else if (div_cnt > 0) begin
        div_cnt--;
        if (s.rst_div && div_cnt == 3) begin
          #2 Srst_n = 0;
          #1;
          check({nm, "_rst_ocupado"}, int'(ocupado), 0);
          check({nm, "_rst_saida"}, int'(saida_defuzzy), 0);
          check({nm, "_rst_sem"}, int'(sem_regra), 0);
          check({nm, "_rst_num"}, int'(div_num), 0);
          check({nm, "_rst_den"}, int'(div_den), 0);
          check({nm, "_rst_idx"}, int'(regra_idx), 0);
          @(negedge clk_0);
          Srst_n = 1;
          return;
        end
        if (div_cnt == 0) begin
          div_done = 1;
          div_quoc = 8'(s.quoc);
          check({nm, "_num_held"}, int'(div_num), s.num);
          check({nm, "_den_held"}, int'(div_den), s.den);
          div_cnt = -1;
        end
      end
      if (saida_valida) begin
        done = 1;
        check({nm, "_out"}, int'(saida_defuzzy), s.out);
        check({nm, "_sem"}, int'(sem_regra), int'(s.sem));
        if (s.lat > 0) check({nm, "_latency"}, cyc - 1, s.lat);
      end
      inicio = s.stress && (cyc == 4 || cyc == 12);
      if (!done) @(negedge clk_0);
    end
    fire_valid = 0;
    inicio     = 0;
    check({nm, "_finished"}, int'(done), 1);
    check({nm, "_nreq"}, nreq, s.nreq);
    check({nm, "_ndiv"}, ndiv, s.ndiv);
    check({nm, "_reset_mem"}, nrst, 1);
    @(negedge clk_0);
    check({nm, "_valida_1cyc"}, int'(saida_valida), 0);
    check({nm, "_idle"}, int'(ocupado), 0);
    repeat (2) @(negedge clk_0);
    check({nm, "_no_rerun"}, int'(ocupado), 0);
  endtask

  initial begin
    //            mask       wu   wl  cmul cadd quoc dly st nreq ndiv num      den   out  sem lat ab  rst
    tbl[0]  = '{6'b111111, 100,  50, 20,   0,  80,  3, 0, 9, 1, 108000,  1350,  80, 0, 0, -1, 0};
    tbl[1]  = '{6'b001001, 200, 100,  0, 170, 170,  2, 0, 1, 1,  51000,   300, 170, 0, 0, -1, 0};
    tbl[2]  = '{6'b000000,   0,   0,  0,   0,   0,  2, 0, 0, 0,      0,     0,   0, 1, 10, -1, 0};
    tbl[3]  = '{6'b010110,  10,   5,  1,   3,   9,  1, 0, 2, 1,    255,    30,   9, 0, 0, -1, 0};
    tbl[4]  = '{6'b111111, 255, 255,  0, 255, 255,  4, 0, 9, 1, 1170450, 4590, 255, 0, 0, -1, 0};
    tbl[5]  = '{6'b001001,   0,   0,  0,  99,   0,  2, 0, 1, 0,      0,     0,   0, 1, 0, -1, 0};
    tbl[6]  = '{6'b100100,   1,   0,  0, 200, 200,  2, 0, 1, 1,    200,     1, 200, 0, 0, -1, 0};
    tbl[7]  = '{6'b111111, 100,  50, 20,   0,  80,  3, 0, 9, 1, 108000,  1350,  80, 0, 0, -1, 0};
    tbl[8]  = '{6'b111111, 100,  50, 20,   0,  80,  3, 0, 9, 1, 108000,  1350,  80, 0, 0,  4, 0};
    tbl[9]  = '{6'b111111, 100,  50, 20,   0,  80, 20, 1, 9, 1, 108000,  1350,  80, 0, 0, -1, 0};
    tbl[10] = '{6'b111111, 100,  50, 20,   0,  80,  6, 0, 9, 1, 108000,  1350,  80, 0, 0, -1, 1};
    tbl[11] = '{6'b111111, 100,  50, 20,   0,  80,  3, 0, 9, 1, 108000,  1350,  80, 0, 0, -1, 0};

    Srst_n = 0; EN_REGRAS = 1; inicio = 0; FOU_ATIVO = '0;
    fire_valid = 0; div_done = 0; div_quoc = '0;
    w_up = '0; w_low = '0; centroide = '0;
    repeat (2) @(negedge clk_0);
    check("reset_ocupado", int'(ocupado), 0);
    check("reset_saida", int'(saida_defuzzy), 0);
    check("reset_sem", int'(sem_regra), 0);
    check("reset_num", int'(div_num), 0);
    check("reset_idx", int'(regra_idx), 0);
    Srst_n = 1;
    @(negedge clk_0);

    // inicio without EN_REGRAS must not start a run
    EN_REGRAS = 0;
    inicio    = 1;
    FOU_ATIVO = 6'b111111;
    @(negedge clk_0);
    check("no_start_when_disabled", int'(ocupado), 0);
    inicio    = 0;
    EN_REGRAS = 1;
    @(negedge clk_0);

    for (int t = 0; t < 12; t++) run(tbl[t], $sformatf("vec%0d", t));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fuzzy_rule_sequencer.md
Name: fuzzy_rule_sequencer

Overview:
Control FSM for the two-input interval type-2 fuzzy controller datapath. On each start request it does the following in order:
- pulses the membership-memory reset;
- walks the N_FOU×N_FOU rule base and skips rules whose input FOUs are inactive;
- requests upper/lower firing strengths from the rule-evaluation stage and accumulates the centroid numerator and denominator;
- hands both sums to the shared divider and registers the defuzzified output.

It sits between the fuzzifier (source of FOU_ATIVO) and the defuzzifier divider.

Parameters:
N_FOU, 3, FOUs per input; the rule count is N_FOU*N_FOU.
W_DADO, 8, width of firing strengths, centroids and output.
W_ACC, 24, accumulator and divider operand width.
W_IDX, 4, rule index width; must satisfy 2^W_IDX >= N_FOU*N_FOU.

Ports:
clk_0  in  1  single system clock, rising edge
Srst_n  in  1  asynchronous active-low reset
EN_REGRAS  in  1  rule-engine enable; low aborts any run
inicio  in  1  start request, sampled only in IDLE
FOU_ATIVO  in  2*N_FOU  active mask; [N_FOU-1:0] = input 1, [2*N_FOU-1:N_FOU] = input 2
ocupado  out  1  high in every state except IDLE
reset_mem  out  1  one-cycle pulse clearing membership memory
regra_idx  out  W_IDX  current rule k = i*N_FOU + j (i = input-1 FOU, j = input-2 FOU)
regra_req  out  1  firing-strength request, held until fire_valid
fire_valid  in  1  strengths valid for regra_idx
w_up  in  W_DADO  upper firing strength
w_low  in  W_DADO  lower firing strength
centroide  in  W_DADO  consequent centroid of rule k
div_start  out  1  one-cycle divider start pulse
div_num  out  W_ACC  numerator, held stable from div_start until div_done
div_den  out  W_ACC  denominator, held stable from div_start until div_done
div_done  in  1  divider result valid
div_quoc  in  W_DADO  quotient
saida_defuzzy  out  W_DADO  registered crisp output
saida_valida  out  1  one-cycle result strobe
sem_regra  out  1  last run had a zero denominator

Behaviour:
- Reset (Srst_n low, any time, asynchronous): state = IDLE. Every output and internal register is 0: k, num, den, saida_defuzzy, sem_regra.
- States: IDLE, CLR_MEM, SCAN, WAIT_FIRE, DIV_START, DIV_WAIT, FIM.
- IDLE: when inicio=1 and EN_REGRAS=1, go to CLR_MEM. In the same edge, clear num/den/k and latch FOU_ATIVO into a mask register, which is used for the whole run.
- CLR_MEM: reset_mem=1 for exactly this cycle, then go to SCAN.
- SCAN, rule k active (mask[k/N_FOU] and mask[N_FOU + k%N_FOU] both set): assert regra_req with regra_idx=k and go to WAIT_FIRE.
- SCAN, rule k inactive: one cycle per skipped rule. If k is the last rule, go to the end decision; otherwise k increments.
- WAIT_FIRE: regra_req stays high until fire_valid. On the fire_valid edge:
  - s = w_up + w_low, (W_DADO+1) bits;
  - den += s;
  - num += s*centroide, (2*W_DADO+1)-bit product, zero-extended;
  - regra_req drops, then k increments (back to SCAN) or, on the last rule, go to the end decision.
- End decision: den≠0 → DIV_START; den=0 → FIM with sem_regra=1.
- fire_valid outside WAIT_FIRE is ignored.
- DIV_START: div_start=1 for one cycle, div_num=num, div_den=den, then go to DIV_WAIT.
- DIV_WAIT: on div_done, saida_defuzzy ← div_quoc, sem_regra ← 0, go to FIM.
- FIM: saida_valida=1 for one cycle, then go to IDLE.
  - On sem_regra, saida_defuzzy ← 0.
  - saida_defuzzy holds its value until the next FIM.
- Accumulation does not saturate. The worst case, 9×510×255 = 1,170,450, fits in W_ACC=24.
- EN_REGRAS=0 in any non-IDLE state: go to IDLE at the next edge. regra_req and div_start drop, and there is no saida_valida. saida_defuzzy and sem_regra keep their previous values. A div_done arriving later is ignored.
- inicio while ocupado=1 is ignored; it is not queued.
- Latency with all rules skipped (N_FOU=3): saida_valida is high in the cycle following the 10th rising edge after the edge that sampled inicio.

Test Plan:
- Full mask, all active: FOU_ATIVO=6'b111111; each fire returns w_up=100, w_low=50, centroide=20*k. Required: regra_req for k=0..8 in order; div_num=108000, div_den=1350; div_quoc=80 → saida_defuzzy=80; one-cycle saida_valida; sem_regra=0.
- Single rule: FOU_ATIVO=6'b001001; fire returns w_up=200, w_low=100, centroide=170. Required: only regra_idx=0 requested; div_num=51000, div_den=300; divider returns 170 → output 170.
- Empty mask: FOU_ATIVO=0. Required:
  - reset_mem pulses once;
  - no regra_req and no div_start;
  - sem_regra=1, saida_defuzzy=0;
  - saida_valida exactly 10 edges after inicio is sampled.
- Abort: drop EN_REGRAS while in WAIT_FIRE on k=4. Required: IDLE next cycle, ocupado=0, regra_req=0, no saida_valida, previous output of 80 retained. A late div_done is ignored.
- Protocol stress: hold fire_valid high outside requests, pulse inicio while busy, and delay div_done by 20 cycles. Required: results identical to the full-mask scenario, and no second run starts.
- Asynchronous reset: assert Srst_n=0 mid-DIV_WAIT, between clock edges. Required: all outputs 0 immediately; after release, a fresh run completes normally.
